reg_pipe: RTL
=============

# reg_pipe

Parametrised elastic pipeline register: the next generation of the team's single-stage clocked register. It chains DEPTH stages of DATAWIDTH-bit storage with a per-stage valid bit and a valid/ready handshake at both ends. Bubbles collapse under backpressure, an occupancy count is exported, and a synchronous flush is provided. It sits between datapath units that need fixed-latency registering and must also tolerate downstream stalls.

## Interface
- DATAWIDTH, 64, bit width of d and q.
- DEPTH, 4, number of register stages (legal range 1..16).
- Clk  input  1  clock; all state changes on rising edge.
- Rst  input  1  reset, synchronous and active-low (0 = reset, sampled on rising Clk).
- flush  input  1  synchronous clear of all valid bits.
- in_valid  input  1  upstream word present on d.
- in_ready  output  1  pipe can accept d this cycle.
- d  input  DATAWIDTH  input data.
- out_valid  output  1  q holds a valid word.
- out_ready  input  1  downstream accepts q this cycle.
- q  output  DATAWIDTH  output data; always equals last-stage data register.
- count  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH.

## Operation
- State per stage i (0 = input side, DEPTH-1 = output side): v[i] and data[i].
- Stage advance condition: adv[i] = ~v[i] | adv[i+1], with adv[DEPTH] = out_ready.
- in_ready = adv[0] & ~flush. out_valid = v[DEPTH-1] & ~flush.
- Input transfer (in_xfer) = in_valid & in_ready. Output transfer (out_xfer) = out_valid & out_ready.
- On each edge, every stage with adv[i]=1 loads from its predecessor: data[i] <= data[i-1], v[i] <= v[i-1]. Stage 0 loads d and in_xfer.
- Stages with adv[i]=0 hold both data and valid.
- Data registers load regardless of the incoming valid bit. Only the valid bits qualify contents.
- Bubble collapse: an empty stage always accepts, so a stall fills empty stages before in_ready falls.
- count is the next-state population of v:
  - +1 on in_xfer without out_xfer.
  - -1 on out_xfer without in_xfer.
  - Unchanged when both or neither occur.
- count never exceeds DEPTH and never goes below 0.
- flush=1:
  - All v[i] <= 0 and count <= 0 at the edge.
  - No transfers occur that cycle because in_ready and out_valid are both forced 0.
  - Data registers are not cleared.
- Rst=0 overrides flush. At the edge, all v[i]=0, all data[i]=0, count=0.

## Timing
- Reset values after the Rst=0 edge: out_valid=0, q=0, count=0. in_ready=1 whenever flush=0 (pipe empty).
- Latency: a word accepted in cycle n appears with out_valid=1 in cycle n+DEPTH, provided no stall occurs in between.
- Throughput: 1 word/cycle sustained while out_ready=1.
- out_ready to in_ready is a combinational path through the adv chain. No combinational path runs from in_valid to any output.
- Full (count=DEPTH):
  - out_ready=0 gives in_ready=0.
  - out_ready=1 gives in_ready=1, with simultaneous accept and emit; count stays at DEPTH.
- Empty (count=0): out_valid=0, and q shows stale data.
- Simultaneous flush and in_valid: the word is dropped and count becomes 0.
- Reset asserted mid-stream: all in-flight words are discarded at that edge. Accepting resumes in the first cycle with Rst=1.
- DEPTH=1 degenerates to a single register with handshake. It is full-throughput only when out_ready=1.

## Test plan
- Reset: hold Rst=0 for 2 cycles with in_valid=1, d=8'hAA (DATAWIDTH=8, DEPTH=4) -> out_valid=0, q=0, count=0, in_ready=1 after release.
- Streaming: out_ready=1, send d=1,2,3,4,5 on consecutive cycles from cycle 0 -> out_valid rises in cycle 4 with q=1, then q=2,3,4,5 in cycles 5-8. count stays at most 4.
- Backpressure/fill: out_ready=0, offer 6 words 10..15 -> words 10..13 accepted and in_ready=0 from the 5th cycle. count=4, q=10 held. Then out_ready=1 for 4 cycles -> q=10,11,12,13, count ends 0 if in_valid=0.
- Full pass-through: with count=4, drive out_ready=1 and in_valid=1, d=20 -> same-cycle emit of q (oldest word) and accept of 20, count remains 4.
- Flush: with count=3, assert flush for 1 cycle with in_valid=1, d=7 -> in_ready=0 and out_valid=0 that cycle, count=0 next cycle, word 7 never appears at q.
- Reset mid-stream: Rst=0 for 1 cycle while count=2 and out_ready=1 -> count=0, out_valid=0, q=0 next cycle. The two words never emerge.

Source files
------------

// File: rtl/reg_pipe.sv
// reg_pipe: elastic pipeline of DEPTH registered stages with a valid/ready
// handshake on both ends. Stalls fill empty stages first (bubble collapse).
// The module exports an occupancy count and has a synchronous flush.
module reg_pipe #(
  parameter int DATAWIDTH = 64,
  parameter int DEPTH     = 4
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATAWIDTH-1:0]         d,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATAWIDTH-1:0]         q,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DATAWIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]     r_vld;
  logic [CW-1:0]        r_count;

  logic [DEPTH-1:0]     w_adv;
  logic                 w_in_xfer;
  logic                 w_out_xfer;

  // Advance chain from the output side back to the input side.
  // A stage may load when it is empty or when its successor advances.
  // The running OR avoids a self-referencing vector, which simulators and lint tools handle poorly.
  always_comb begin : adv_chain
    logic acc;
    acc   = out_ready;
    w_adv = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      acc      = acc | ~r_vld[i];
      w_adv[i] = acc;
    end
  end

  // flush masks both handshakes, so no word enters or leaves in a flush cycle.
  assign in_ready   = w_adv[0] & ~flush;
  assign out_valid  = r_vld[DEPTH-1] & ~flush;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  assign q     = r_data[DEPTH-1];
  assign count = r_count;

  // Valid bits: cleared by reset or flush, otherwise shift on advance.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_vld <= '0;
    end else if (flush) begin
      r_vld <= '0;
    end else begin
      if (w_adv[0]) r_vld[0] <= w_in_xfer;
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i]) r_vld[i] <= r_vld[i-1];
      end
    end
  end

  // Data registers: load on advance regardless of valid. Only reset clears them; flush does not.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      if (w_adv[0]) r_data[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i]) r_data[i] <= r_data[i-1];
      end
    end
  end

  // Occupancy: tracks the next-state population of the valid bits.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_count <= r_count + CW'(1);
    end else if (w_out_xfer && !w_in_xfer) begin
      r_count <= r_count - CW'(1);
    end
  end

endmodule
